// File: rtl/overload_frame_if.sv
// Bus-side signals of the CAN overload frame generator.
// The interframe tracker / bus model drives the master side; the generator is the slave.
interface overload_frame_if;
  logic canRX;
  logic isOverload;
  logic isStart;
  logic canTX;
  logic endOverload;
  logic overloadActive;
  logic bitError;
  logic limitHit;

  modport master (
    output canRX, isOverload, isStart,
    input  canTX, endOverload, overloadActive, bitError, limitHit
  );

  modport slave (
    input  canRX, isOverload, isStart,
    output canTX, endOverload, overloadActive, bitError, limitHit
  );
endinterface

// File: rtl/overload_frame.sv
// CAN overload frame generator: the flag, a wait for other nodes' flags to end, then the
// delimiter. It advances one step per bit on samplePoint and returns endOverload to the tracker.
module overload_frame #(
  parameter int FLAG_LEN      = 6,
  parameter int MAX_SUPERPOS  = 7,
  parameter int DELIM_LEN     = 8,
  parameter int MAX_OVERLOADS = 2,
  parameter int CNT_W         = 4
) (
  input  logic              samplePoint,
  input  logic              reset,
  overload_frame_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLAG     = 2'd1,
    WAIT_REC = 2'd2,
    DELIM    = 2'd3
  } state_t;

  state_t             state, stateNext;
  logic [CNT_W-1:0]   bitCnt, bitCntNext;
  logic [CNT_W-1:0]   ovlCnt, ovlCntNext, ovlBase;
  logic               canTXReg, canTXNext;
  logic               endReg, endNext;
  logic               activeReg, activeNext;
  logic               errReg, errNext;
  logic               limitReg, limitNext;

  assign bus.canTX          = canTXReg;
  assign bus.endOverload    = endReg;
  assign bus.overloadActive = activeReg;
  assign bus.bitError       = errReg;
  assign bus.limitHit       = limitReg;

  // State, counters and registered outputs; reset drops canTX to recessive at once.
  always_ff @(posedge samplePoint or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bitCnt    <= {CNT_W{1'b0}};
      ovlCnt    <= {CNT_W{1'b0}};
      canTXReg  <= 1'b1;
      endReg    <= 1'b0;
      activeReg <= 1'b0;
      errReg    <= 1'b0;
      limitReg  <= 1'b0;
    end else begin
      state     <= stateNext;
      bitCnt    <= bitCntNext;
      ovlCnt    <= ovlCntNext;
      canTXReg  <= canTXNext;
      endReg    <= endNext;
      activeReg <= activeNext;
      errReg    <= errNext;
      limitReg  <= limitNext;
    end
  end

  // Next-state and next-output decode for one bit period.
  always_comb begin
    // isStart clears the budget before a same-edge request is judged against it
    ovlBase    = bus.isStart ? {CNT_W{1'b0}} : ovlCnt;
    stateNext  = state;
    bitCntNext = bitCnt;
    ovlCntNext = ovlBase;
    canTXNext  = canTXReg;
    activeNext = activeReg;
    endNext    = 1'b0;
    errNext    = 1'b0;
    limitNext  = 1'b0;

    case (state)
      IDLE: begin
        canTXNext  = 1'b1;
        activeNext = 1'b0;
        bitCntNext = {CNT_W{1'b0}};
        if (bus.isOverload) begin
          if (ovlBase < CNT_W'(MAX_OVERLOADS)) begin
            stateNext  = FLAG;
            canTXNext  = 1'b0;
            activeNext = 1'b1;
            ovlCntNext = ovlBase + CNT_W'(1);
          end else begin
            limitNext = 1'b1;
          end
        end else begin
          stateNext = IDLE;
        end
      end

      FLAG: begin
        if (bus.canRX) begin
          errNext    = 1'b1;
          stateNext  = IDLE;
          canTXNext  = 1'b1;
          activeNext = 1'b0;
          bitCntNext = {CNT_W{1'b0}};
        end else if (bitCnt == CNT_W'(FLAG_LEN - 1)) begin
          stateNext  = WAIT_REC;
          canTXNext  = 1'b1;
          bitCntNext = {CNT_W{1'b0}};
        end else begin
          bitCntNext = bitCnt + CNT_W'(1);
        end
      end

      WAIT_REC: begin
        if (!bus.canRX) begin
          // Other nodes may still be flagging; too long a dominant run is an error
          if (bitCnt == CNT_W'(MAX_SUPERPOS)) begin
            errNext    = 1'b1;
            stateNext  = IDLE;
            activeNext = 1'b0;
            bitCntNext = {CNT_W{1'b0}};
          end else begin
            bitCntNext = bitCnt + CNT_W'(1);
          end
        end else begin
          stateNext  = DELIM;
          bitCntNext = CNT_W'(1);
        end
      end

      DELIM: begin
        if (!bus.canRX) begin
          errNext    = 1'b1;
          stateNext  = IDLE;
          activeNext = 1'b0;
          bitCntNext = {CNT_W{1'b0}};
        end else if (bitCnt == CNT_W'(DELIM_LEN - 1)) begin
          endNext    = 1'b1;
          stateNext  = IDLE;
          activeNext = 1'b0;
          bitCntNext = {CNT_W{1'b0}};
        end else begin
          bitCntNext = bitCnt + CNT_W'(1);
        end
      end

      default: begin
        stateNext  = IDLE;
        canTXNext  = 1'b1;
        activeNext = 1'b0;
        bitCntNext = {CNT_W{1'b0}};
      end
    endcase
  end

endmodule

// File: tb/tb_overload_frame.sv
// Directed bench for overload_frame: clean frame, superposition, monitor/form errors,
// overload budget and asynchronous reset.
module tb_overload_frame;
  logic samplePoint;
  logic reset;
  int   total;
  int   bad;

  overload_frame_if bus();

  overload_frame dut (
    .samplePoint (samplePoint),
    .reset       (reset),
    .bus         (bus)
  );

  initial begin
    samplePoint = 1'b0;
    forever #5 samplePoint = ~samplePoint;
  end

  task automatic check1(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic chk(input string tag, input logic eTx, input logic eEnd,
                     input logic eAct, input logic eErr, input logic eLim);
    check1({tag, ".canTX"},          bus.canTX,          eTx);
    check1({tag, ".endOverload"},    bus.endOverload,    eEnd);
    check1({tag, ".overloadActive"}, bus.overloadActive, eAct);
    check1({tag, ".bitError"},       bus.bitError,       eErr);
    check1({tag, ".limitHit"},       bus.limitHit,       eLim);
  endtask

  // Drive inputs, let one active edge pass, settle 1 time unit.
  task automatic tick(input logic rx, input logic ovl, input logic start);
    bus.canRX      = rx;
    bus.isOverload = ovl;
    bus.isStart    = start;
    @(posedge samplePoint);
    #1;
  endtask

  // Accepted request with canRX following canTX: 6 flag edges, end pulse 14 edges in.
  task automatic cleanFrame(input string tag, input logic start);
    tick(1'b1, 1'b1, start);
    chk({tag, "_accept"}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      chk($sformatf("%s_flag%0d", tag, i), (i == 6), 1'b0, 1'b1, 1'b0, 1'b0);
    end
    for (int i = 7; i <= 13; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      chk($sformatf("%s_rec%0d", tag, i), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    tick(1'b1, 1'b0, 1'b0);
    chk({tag, "_end"}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk({tag, "_after"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Accept, then drive the 6 flag edges with the bus dominant.
  task automatic startFlag(input string tag, input logic start);
    tick(1'b1, 1'b1, start);
    chk({tag, "_accept"}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      tick(1'b0, 1'b0, 1'b0);
    end
    chk({tag, "_flagdone"}, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.canRX      = 1'b1;
    bus.isOverload = 1'b0;
    bus.isStart    = 1'b0;
    reset          = 1'b0;
    #1 reset = 1'b1;
    #3;
    chk("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge samplePoint);
    reset = 1'b0;

    // Clean frame (budget 1)
    cleanFrame("clean", 1'b0);

    // 7 extra dominant bits tolerated; isStart on the accept edge resets budget to 0 then 1
    startFlag("sup7", 1'b1);
    for (int i = 1; i <= 7; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      chk($sformatf("sup7_dom%0d", i), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    for (int i = 1; i <= 7; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      chk($sformatf("sup7_rec%0d", i), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    tick(1'b1, 1'b0, 1'b0);
    chk("sup7_end", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // 8 extra dominant bits: error on the 8th
    startFlag("sup8", 1'b1);
    for (int i = 1; i <= 7; i++) begin
      tick(1'b0, 1'b0, 1'b0);
    end
    chk("sup8_dom7", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("sup8_err", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("sup8_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1, 1'b0, 1'b0);
    end
    chk("sup8_noend", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Flag monitor fault on 3rd flag edge
    tick(1'b1, 1'b1, 1'b1);
    chk("mon_accept", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("mon_flag2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("mon_err", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("mon_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Delimiter form error on 4th delimiter bit
    startFlag("form", 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("form_delim3", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("form_err", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("form_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Budget: clear, two frames, third refused
    tick(1'b1, 1'b0, 1'b1);
    chk("bud_clear", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cleanFrame("budA", 1'b0);
    cleanFrame("budB", 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    chk("bud_limit", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    chk("bud_limitpulse", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    cleanFrame("budC", 1'b0);

    // Budget now 1; accept (->2), then async reset mid 3rd flag bit
    tick(1'b1, 1'b1, 1'b0);
    chk("rst_accept", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("rst_flag2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #3 reset = 1'b1;
    #1;
    chk("rst_async", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b0;
    cleanFrame("rstA", 1'b0);
    cleanFrame("rstB", 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    chk("rst_limit", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
